fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined MIPS datapath. It owns the program counter and the IF/ID pipeline register. It obeys the stall controls PCWrite/IFWrite from the hazard unit and applies control-flow redirects: jumps resolved in ID and taken branches resolved in MEM. Its outputs feed the decode stage and the hazard unit's register-compare logic.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 50 +++++
 tb/tb_fetch_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: handshake/bus bundle between the fetch stage and its surroundings.
// Signals: PCWrite/IFWrite (stall), Jump/BranchTaken/BranchTarget (redirect),
// InstrAddr/InstrIn (instruction memory), IFID_* and FetchCount (to decode/hazard unit).
interface fetch_stage_if;
  logic        PCWrite;
  logic        IFWrite;
  logic        Jump;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] InstrAddr;
  logic [31:0] InstrIn;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] FetchCount;
  modport master (
    output PCWrite, IFWrite, Jump, BranchTaken, BranchTarget, InstrIn,
    input  InstrAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid, FetchCount
  );
  modport slave (
    input  PCWrite, IFWrite, Jump, BranchTaken, BranchTarget, InstrIn,
    output InstrAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid, FetchCount
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch; owns the PC and the IF/ID register.
// Ports: CLK, Reset_L (async active-low), bus (fetch_stage_if.slave) carrying
// stall controls, redirects, instruction memory access, IF/ID outputs and FetchCount.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic         CLK,
  input logic         Reset_L,
  fetch_stage_if.slave bus
);
  logic [31:0] pc, pc_plus4, jump_target, next_pc;
  logic [31:0] ifid_instr, ifid_pc_plus4, fetch_count;
  logic        ifid_valid, redirect, load;
  assign pc_plus4    = pc + 32'd4;
  // Jump fields come from the jump itself, which sits in IF/ID while it decodes.
  assign jump_target = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00};
  assign redirect    = bus.BranchTaken | bus.Jump;
  assign load        = !redirect && bus.IFWrite;
  // The branch is older than the jump, so it wins; a redirect also overrides a stall.
  always_comb
    next_pc = bus.BranchTaken ? {bus.BranchTarget[31:2], 2'b00} :
              bus.Jump        ? jump_target :
              bus.PCWrite     ? pc_plus4 : pc;
  always_ff @(posedge CLK or negedge Reset_L)
    if (!Reset_L) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
      fetch_count   <= '0;
    end else begin
      pc <= next_pc;
      if (redirect) begin
        ifid_instr    <= NOP_INSTR;
        ifid_pc_plus4 <= '0;
        ifid_valid    <= 1'b0;
      end else if (bus.IFWrite) begin
        ifid_instr    <= bus.InstrIn;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid    <= 1'b1;
      end
      if (load) fetch_count <= fetch_count + 32'd1;
    end
  assign bus.InstrAddr    = pc;
  assign bus.IFID_Instr   = ifid_instr;
  assign bus.IFID_PCPlus4 = ifid_pc_plus4;
  assign bus.IFID_Valid   = ifid_valid;
  assign bus.FetchCount   = fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  logic CLK = 1'b0;
  logic Reset_L = 1'b1;
  logic jmp_at4 = 1'b0;
  int   errors = 0;
  int   checks = 0;
  fetch_stage_if bus();
  fetch_stage dut (.CLK(CLK), .Reset_L(Reset_L), .bus(bus));
  always #5 CLK = ~CLK;
  always_comb
    bus.InstrIn = (jmp_at4 && bus.InstrAddr == 32'h4) ? 32'h0800_0040 : (32'h2000_0000 | bus.InstrAddr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                          input logic valid, input logic [31:0] cnt, input logic [31:0] addr);
    chk({tag, ".instr"}, bus.IFID_Instr, instr);
    chk({tag, ".pc4"}, bus.IFID_PCPlus4, pc4);
    chk({tag, ".valid"}, {31'd0, bus.IFID_Valid}, {31'd0, valid});
    chk({tag, ".count"}, bus.FetchCount, cnt);
    chk({tag, ".addr"}, bus.InstrAddr, addr);
  endtask
  initial begin
    bus.PCWrite = 1'b1;
    bus.IFWrite = 1'b1;
    bus.Jump = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchTarget = '0;
    #2 Reset_L = 1'b0;
    #1 chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
    Reset_L = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ifid($sformatf("run%0d", k), 32'h2000_0000 | (4 * (k - 1)), 4 * k, 1'b1, k, 4 * k);
    end
    bus.PCWrite = 1'b0;
    bus.IFWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid($sformatf("stall%0d", k), 32'h2000_000C, 32'h10, 1'b1, 32'd4, 32'h10);
    end
    bus.PCWrite = 1'b1;
    bus.IFWrite = 1'b1;
    step();
    chk_ifid("resume", 32'h2000_0010, 32'h14, 1'b1, 32'd5, 32'h14);
    #2 Reset_L = 1'b0;
    #1 chk_ifid("areset", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
    jmp_at4 = 1'b1;
    Reset_L = 1'b1;
    step();
    step();
    chk_ifid("jload", 32'h0800_0040, 32'h8, 1'b1, 32'd2, 32'h8);
    bus.Jump = 1'b1;
    step();
    chk_ifid("jump", 32'h0, 32'h0, 1'b0, 32'd2, 32'h100);
    bus.Jump = 1'b0;
    step();
    chk_ifid("jtgt", 32'h2000_0100, 32'h104, 1'b1, 32'd3, 32'h104);
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'h0000_0203;
    bus.PCWrite = 1'b0;
    step();
    chk_ifid("branch", 32'h0, 32'h0, 1'b0, 32'd3, 32'h200);
    bus.BranchTaken = 1'b0;
    bus.PCWrite = 1'b1;
    step();
    chk_ifid("btgt", 32'h2000_0200, 32'h204, 1'b1, 32'd4, 32'h204);
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'h0000_0080;
    bus.Jump = 1'b1;
    step();
    chk_ifid("both", 32'h0, 32'h0, 1'b0, 32'd4, 32'h80);
    bus.Jump = 1'b0;
    bus.BranchTarget = 32'hFFFF_FFFF;
    step();
    chk("wrap.pc", bus.InstrAddr, 32'hFFFF_FFFC);
    bus.BranchTaken = 1'b0;
    step();
    chk_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd5, 32'h0);
    bus.PCWrite = 1'b0;
    bus.IFWrite = 1'b0;
    step();
    chk("hold.count", bus.FetchCount, 32'd5);
    #2 Reset_L = 1'b0;
    #1 chk_ifid("midreset", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
